// File: rtl/chan_bin_pkg.sv
// rtl/chan_bin_pkg.sv - shared constants and types for the channel-to-bin loader
package chan_bin_pkg;

    // Field positions inside the load-bins register word
    localparam int WE_BIT     = 31;
    localparam int COMMIT_BIT = 30;
    localparam int ADDR_LSB   = 16;
    localparam int BIN_LSB    = 0;

    // Default geometry: 256 channel slots picked from a 512-point FFT
    localparam int DEF_NUM_CH = 256;
    localparam int DEF_CH_W   = 8;
    localparam int DEF_BIN_W  = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/chan_bin_table_ram.sv
// rtl/chan_bin_table_ram.sv - two-bank selection table, one write port and one synchronous read port
module chan_bin_table_ram
    import chan_bin_pkg::*;
#(
    parameter int CH_W  = DEF_CH_W,
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [CH_W:0]    wr_addr_i,
    input  logic [BIN_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [CH_W:0]    rd_addr_i,
    output logic [BIN_W-1:0] rd_data_o
);

    // Address is {bank, ch}; contents are left uninitialised so it maps onto block RAM
    logic [BIN_W-1:0] mem_q [0:(2 << CH_W)-1];

    // Write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Synchronous read port, one cycle of latency
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/chan_512_clean_bin_loader.sv
// rtl/chan_512_clean_bin_loader.sv - double-buffered channel-to-FFT-bin table with per-frame sweep
module chan_512_clean_bin_loader
    import chan_bin_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = DEF_CH_W,
    parameter int BIN_W  = DEF_BIN_W
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic [31:0]      load_word,
    input  logic             sync_in,
    output logic             sync_out,
    output logic             sel_valid,
    output logic [CH_W-1:0]  ch_idx,
    output logic [BIN_W-1:0] bin_sel,
    output logic             active_bank,
    output logic             commit_pending
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [31:0]      lw_q, lw_qq;
    logic             wr_edge, commit_edge, swap;
    logic             active_bank_q, active_bank_d;
    logic             commit_pending_q, commit_pending_d;
    sweep_state_t     state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             rd_en;
    logic [CH_W:0]    wr_addr, rd_addr;
    logic [BIN_W-1:0] wr_data, rd_data;
    logic             v1_q, sync1_q;
    logic [CH_W-1:0]  ch1_q;
    logic             sel_valid_q, sync_out_q;
    logic [CH_W-1:0]  ch_idx_q;
    logic [BIN_W-1:0] bin_sel_q;
    logic             unused_lw;

    // Only the strobe, address and bin fields matter; the rest of the word is ignored
    assign unused_lw = ^{lw_q, lw_qq};

    // Register the software word and keep the previous copy for edge detection
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            lw_q  <= '0;
            lw_qq <= '0;
        end else begin
            lw_q  <= load_word;
            lw_qq <= lw_q;
        end
    end

    // Strobe edges, bank swap decision and commit bookkeeping
    always_comb begin
        wr_edge          = lw_q[WE_BIT] & ~lw_qq[WE_BIT];
        commit_edge      = lw_q[COMMIT_BIT] & ~lw_qq[COMMIT_BIT];
        swap             = sync_in & (commit_pending_q | commit_edge);
        active_bank_d    = active_bank_q ^ swap;
        commit_pending_d = commit_pending_q;
        if (swap) begin
            commit_pending_d = 1'b0;
        end else if (commit_edge) begin
            commit_pending_d = 1'b1;
        end
    end

    // Bank and commit state registers
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            active_bank_q    <= 1'b0;
            commit_pending_q <= 1'b0;
        end else begin
            active_bank_q    <= active_bank_d;
            commit_pending_q <= commit_pending_d;
        end
    end

    // Sweep next state: ch_d is the slot whose read is issued this cycle
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            IDLE: begin
                if (sync_in) begin
                    state_d = RUN;
                    ch_d    = '0;
                end
            end
            RUN: begin
                if (sync_in) begin
                    ch_d = '0;
                end else if (ch_q == LAST_CH) begin
                    state_d = IDLE;
                    ch_d    = '0;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // Sweep state register and slot counter
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Reads use the post-swap bank so the sweep launched by a swapping sync sees the new table;
    // writes go to the opposite bank, so a same-cycle read and write never share a bank
    assign rd_en   = (state_d == RUN);
    assign rd_addr = {active_bank_d, ch_d};
    assign wr_addr = {~active_bank_d, lw_q[ADDR_LSB +: CH_W]};
    assign wr_data = lw_q[BIN_LSB +: BIN_W];

    chan_bin_table_ram #(
        .CH_W  (CH_W),
        .BIN_W (BIN_W)
    ) u_table (
        .clk_i     (user_clk),
        .wr_en_i   (wr_edge),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Side-band pipeline matching the RAM read latency
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            v1_q    <= 1'b0;
            sync1_q <= 1'b0;
            ch1_q   <= '0;
        end else begin
            v1_q    <= rd_en;
            sync1_q <= sync_in;
            ch1_q   <= ch_d;
        end
    end

    // Output register; slot and bin hold their last value between sweeps
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            sel_valid_q <= 1'b0;
            sync_out_q  <= 1'b0;
            ch_idx_q    <= '0;
            bin_sel_q   <= '0;
        end else begin
            sel_valid_q <= v1_q;
            sync_out_q  <= sync1_q;
            if (v1_q) begin
                ch_idx_q  <= ch1_q;
                bin_sel_q <= rd_data;
            end
        end
    end

    assign sel_valid      = sel_valid_q;
    assign sync_out       = sync_out_q;
    assign ch_idx         = ch_idx_q;
    assign bin_sel        = bin_sel_q;
    assign active_bank    = active_bank_q;
    assign commit_pending = commit_pending_q;

endmodule

// File: tb/tb_chan_512_clean_bin_loader.sv
// tb/tb_chan_512_clean_bin_loader.sv - scoreboard bench for the channel-to-bin loader
module tb_chan_512_clean_bin_loader;

    localparam int NUM_CH = 256;
    localparam int CH_W   = 8;
    localparam int BIN_W  = 9;

    logic             user_clk = 1'b0;
    logic             user_rst = 1'b1;
    logic [31:0]      load_word = '0;
    logic             sync_in = 1'b0;
    logic             sync_out, sel_valid, active_bank, commit_pending;
    logic [CH_W-1:0]  ch_idx;
    logic [BIN_W-1:0] bin_sel;

    chan_512_clean_bin_loader #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .BIN_W  (BIN_W)
    ) dut (
        .user_clk       (user_clk),
        .user_rst       (user_rst),
        .load_word      (load_word),
        .sync_in        (sync_in),
        .sync_out       (sync_out),
        .sel_valid      (sel_valid),
        .ch_idx         (ch_idx),
        .bin_sel        (bin_sel),
        .active_bank    (active_bank),
        .commit_pending (commit_pending)
    );

    always #5 user_clk = ~user_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int ch;
        int bin;
        bit first;
    } exp_t;

    exp_t             sb[$];
    logic [BIN_W-1:0] mdl [0:1][0:NUM_CH-1];
    bit               mbank = 1'b0;
    bit               mpend = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge user_clk) cyc <= cyc + 1;

    // Compare every post-reset cycle against the scoreboard head
    always @(negedge user_clk) begin : monitor
        exp_t e;
        bit   ev;
        if (!user_rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check_eq("slot_late", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            ev = (sb.size() > 0) && (sb[0].cyc == cyc);
            check_eq("sel_valid", sel_valid, ev);
            if (ev) begin
                e = sb.pop_front();
                check_eq("ch_idx", ch_idx, e.ch);
                check_eq("bin_sel", bin_sel, e.bin);
                check_eq("sync_out", sync_out, e.first);
            end else begin
                check_eq("sync_out_idle", sync_out, 0);
            end
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int bin);
        logic [31:0] w;
        w = '0;
        w[31] = 1'b1;
        w[16 +: CH_W] = addr[CH_W-1:0];
        w[0 +: BIN_W] = bin[BIN_W-1:0];
        load_word = w;
        mdl[!mbank][addr] = bin[BIN_W-1:0];
        tick();
        load_word[31] = 1'b0;
        tick();
    endtask

    task automatic commit();
        load_word[30] = 1'b1;
        mpend = 1'b1;
        tick();
        load_word[30] = 1'b0;
        tick();
    endtask

    task automatic pulse_sync();
        exp_t e;
        sync_in = 1'b1;
        if (mpend) begin
            mbank = !mbank;
            mpend = 1'b0;
        end
        while (sb.size() > 0 && sb[$].cyc >= cyc + 2) void'(sb.pop_back());
        for (int k = 0; k < NUM_CH; k++) begin
            e.cyc   = cyc + 2 + k;
            e.ch    = k;
            e.bin   = int'(mdl[mbank][k]);
            e.first = (k == 0);
            sb.push_back(e);
        end
        tick();
        sync_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && sb.size() > 0; i++) tick();
        check_eq("drain", sb.size(), 0);
        tick();
        check_eq("idle_after", sel_valid, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        user_rst = 1'b0;
        check_eq("rst_sel_valid", sel_valid, 0);
        check_eq("rst_sync_out", sync_out, 0);
        check_eq("rst_ch_idx", ch_idx, 0);
        check_eq("rst_bin_sel", bin_sel, 0);
        check_eq("rst_active_bank", active_bank, 0);
        check_eq("rst_commit_pending", commit_pending, 0);
        tick();

        // Bank 1 = ch+100, commit, sweep
        for (int c = 0; c < NUM_CH; c++) write_entry(c, c + 100);
        check_eq("pend_before_commit", commit_pending, 0);
        commit();
        check_eq("pend_after_commit", commit_pending, 1);
        pulse_sync();
        check_eq("bank_after_swap1", active_bank, 1);
        check_eq("pend_after_swap1", commit_pending, 0);
        drain();

        // Bank 0 = ch+200, then a held write strobe that changes bin mid-hold
        for (int c = 0; c < NUM_CH; c++) write_entry(c, c + 200);
        load_word = '0;
        load_word[31] = 1'b1;
        load_word[16 +: CH_W] = 8'd5;
        load_word[0 +: BIN_W] = 9'd7;
        mdl[!mbank][5] = 9'd7;
        repeat (10) tick();
        load_word[0 +: BIN_W] = 9'd9;
        repeat (5) tick();
        load_word = '0;
        repeat (2) tick();

        // Commit edge landing in the sync cycle swaps immediately
        load_word[30] = 1'b1;
        tick();
        mpend = 1'b1;
        pulse_sync();
        check_eq("bank_same_cycle", active_bank, 0);
        for (int i = 0; i < 20; i++) begin
            check_eq("pend_same_cycle", commit_pending, 0);
            tick();
        end
        load_word = '0;
        drain();
        check_eq("pend_same_cycle_end", commit_pending, 0);

        // Restart 100 cycles into a sweep
        pulse_sync();
        repeat (99) tick();
        pulse_sync();
        drain();

        // Write while commit pending lands in the shadow that becomes active
        commit();
        write_entry(3, 40);
        check_eq("pend_with_write", commit_pending, 1);
        pulse_sync();
        check_eq("bank_after_swap2", active_bank, 1);
        drain();
        pulse_sync();
        drain();
        commit();
        pulse_sync();
        check_eq("bank_after_swap3", active_bank, 0);
        drain();

        // Reset mid-sweep with a commit pending
        pulse_sync();
        repeat (20) tick();
        commit();
        repeat (30) tick();
        check_eq("pend_mid_sweep", commit_pending, 1);
        check_eq("valid_mid_sweep", sel_valid, 1);
        user_rst = 1'b1;
        sb.delete();
        mbank = 1'b0;
        mpend = 1'b0;
        tick();
        user_rst = 1'b0;
        check_eq("mid_rst_sel_valid", sel_valid, 0);
        check_eq("mid_rst_sync_out", sync_out, 0);
        check_eq("mid_rst_ch_idx", ch_idx, 0);
        check_eq("mid_rst_bin_sel", bin_sel, 0);
        check_eq("mid_rst_active_bank", active_bank, 0);
        check_eq("mid_rst_commit_pending", commit_pending, 0);
        tick();
        pulse_sync();
        check_eq("bank_after_rst_sync", active_bank, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chan_512_clean_bin_loader.md
# chan_512_clean_bin_loader

Consumes the 32-bit software word driven by the load-bins OPB register in the `user_clk` domain and maintains a double-buffered channel-to-FFT-bin selection table. It streams one selected bin index per channel slot to the downstream bin-select/DDC stage once per FFT frame, aligned to the frame sync pulse. Software fills the shadow bank one entry per register write, then commits. The commit swaps banks atomically at the next frame boundary.

## Interface
Parameters:
- NUM_CH, 256: channel slots per frame; power of two.
- CH_W, 8: channel address width, log2(NUM_CH).
- BIN_W, 9: FFT bin index width; 512-point FFT.

Ports:
- user_clk  in  1  single clock for the whole block.
- user_rst  in  1  synchronous, active-high reset.
- load_word  in  32  register word: [31] write strobe level, [30] commit strobe level, [16+CH_W-1:16] channel address, [BIN_W-1:0] bin value; other bits ignored.
- sync_in  in  1  one-cycle frame-start pulse.
- sync_out  out  1  sync_in delayed to align with the first sel_valid.
- sel_valid  out  1  bin_sel and ch_idx valid.
- ch_idx  out  CH_W  channel slot of the current output.
- bin_sel  out  BIN_W  selected FFT bin for ch_idx.
- active_bank  out  1  bank currently read by the sweep.
- commit_pending  out  1  commit requested, swap not yet taken.

## Operation
- load_word is registered once (lw_q), with a previous copy kept (lw_qq). Edge detection uses lw_q[31]&~lw_qq[31] for a write and lw_q[30]&~lw_qq[30] for a commit. A held level never retriggers.
- Write edge: table[~active_bank][addr] <= bin, using the address and bin fields from lw_q. Writes always target the current shadow bank, including while commit_pending is set.
- Commit edge: commit_pending <= 1. Further commit edges while pending have no extra effect.
- Swap: on a sync_in cycle with commit_pending=1, or with a commit edge in that same cycle, active_bank toggles and commit_pending clears. The sweep started by that sync_in reads the new bank.
- Sweep FSM, states IDLE and RUN:
  - IDLE -> RUN on sync_in; ch counter <= 0.
  - RUN: the counter increments each cycle. After slot NUM_CH-1 the FSM returns to IDLE.
  - sync_in in RUN restarts the counter at 0; the partial sweep is abandoned with no gap.
- Counter wrap is bounded by the FSM. ch_idx never exceeds NUM_CH-1.
- Table RAM is not cleared by reset; software must load both banks before relying on output.
- Reset, including mid-sweep or mid-commit:
  - sel_valid=0, sync_out=0, ch_idx=0, bin_sel=0, active_bank=0, commit_pending=0.
  - FSM=IDLE, edge-detect registers=0.
  - A strobe bit already high at reset release produces one edge, because lw_qq resets to 0. Software is expected to idle both strobe bits low.

## Timing
- Write edge: lw_q captured at cycle t; the RAM write happens at t+1. The entry is readable by a sweep issued at t+2 or later.
- Sweep latency is 2 cycles. sync_in at t gives sync_out=1 and sel_valid=1 with ch_idx=0 at t+2. Slot k appears at t+2+k, and sel_valid stays high for exactly NUM_CH consecutive cycles.
- Read path is a synchronous RAM read (1 cycle) followed by an output register (1 cycle). ch_idx is delayed to match.
- A same-cycle RAM write and read to different banks do not interact. Reads never target the shadow bank.
- active_bank changes at t+1 after the swapping sync_in at t.

## Structure
- Shared package chan_bin_pkg holds:
  - field LSB/MSB constants: WE_BIT=31, COMMIT_BIT=30, ADDR_LSB=16, BIN_LSB=0;
  - default NUM_CH, CH_W, BIN_W;
  - the sweep state enum {IDLE, RUN}.
- One sub-module, chan_bin_table_ram: simple dual-port, depth 2*NUM_CH, address {bank, ch}, width BIN_W, one write port and one synchronous read port, inferred as block RAM.

## Test plan
- Load bank 1 (shadow after reset) with table[ch]=ch+100, commit, pulse sync_in at t -> sel_valid from t+2 to t+257, bin_sel=100..355, sync_out at t+2, active_bank=1.
- Hold load_word[31]=1 for 10 cycles with addr=5, bin=7, then change bin to 9 while the bit stays high -> only the first write lands; table[shadow][5]=7.
- Commit edge in the same cycle as sync_in -> swap in that cycle; the sweep shows the new bank and commit_pending never reads 1 afterwards.
- sync_in again 100 cycles into a sweep -> ch_idx restarts at 0 at +2 cycles; sel_valid stays continuously high; the sweep ends 256 cycles after the restart.
- Writes while commit_pending=1 before sync, addr=3 bin=40 -> after the swap, bin_sel for slot 3 is 40; the old bank is untouched until the next commit.
- Assert user_rst mid-sweep with commit_pending=1 -> next cycle all outputs 0, active_bank=0, commit_pending=0; the next sync_in starts a full sweep from bank 0.
